// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational result and zero flag, plus a
// registered copy of the result for pipelined consumers.
`timescale 1ns/1ps

module rv32i_alu #(
    parameter int unsigned N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        alu_op,
    input  logic [N_BITS-1:0] in0,
    input  logic [N_BITS-1:0] in1,
    output logic [N_BITS-1:0] out,
    output logic              zero,
    output logic [N_BITS-1:0] out_q
);

    localparam int unsigned SHAMT_W = $clog2(N_BITS);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1110;

    logic [SHAMT_W-1:0]       w_shamt;
    logic [N_BITS-1:0]        w_add;
    logic [N_BITS-1:0]        w_sub;
    logic [N_BITS-1:0]        w_sll;
    logic [N_BITS-1:0]        w_srl;
    logic signed [N_BITS-1:0] w_sra;
    logic                     w_lt_s;
    logic                     w_lt_u;
    logic [N_BITS-1:0]        w_out;
    logic [N_BITS-1:0]        r_out_q;

    // Datapath candidates; upper bits of in1 never reach the shifters.
    always_comb begin
        w_shamt = in1[SHAMT_W-1:0];
        w_add   = in0 + in1;
        w_sub   = in0 - in1;
        w_sll   = in0 << w_shamt;
        w_srl   = in0 >> w_shamt;
        w_sra   = $signed(in0) >>> w_shamt;
        w_lt_s  = $signed(in0) < $signed(in1);
        w_lt_u  = in0 < in1;
    end

    // Result select; unassigned op codes resolve to zero.
    always_comb begin
        w_out = '0;
        case (alu_op)
            OP_ADD:  w_out = w_add;
            OP_SUB:  w_out = w_sub;
            OP_SLL:  w_out = w_sll;
            OP_SLT:  w_out = N_BITS'(w_lt_s);
            OP_SLTU: w_out = N_BITS'(w_lt_u);
            OP_XOR:  w_out = in0 ^ in1;
            OP_SRL:  w_out = w_srl;
            OP_SRA:  w_out = w_sra;
            OP_OR:   w_out = in0 | in1;
            OP_AND:  w_out = in0 & in1;
            default: w_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_out;
        end
    end

    assign out   = w_out;
    assign zero  = (w_out == '0);
    assign out_q = r_out_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector and randomized checks for rv32i_alu, including the
// asynchronous reset behaviour of the registered result.
`timescale 1ns/1ps

module tb_rv32i_alu;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] out;
    logic        zero;
    logic [31:0] out_q;

    int n_tests;
    int n_fail;
    vec_t vecs[$];

    rv32i_alu #(.N_BITS(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_op (alu_op),
        .in0    (in0),
        .in1    (in1),
        .out    (out),
        .zero   (zero),
        .out_q  (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written independently of the RTL operators.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] ones;
        sh   = b[4:0];
        ones = 32'hFFFF_FFFF;
        case (op)
            4'b0000: return a + b;
            4'b0001: return a + ~b + 32'd1;
            4'b0010: return a << sh;
            4'b0100: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0110: return (a < b) ? 32'd1 : 32'd0;
            4'b1000: return a ^ b;
            4'b1010: return a >> sh;
            4'b1011: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'b1100: return a | b;
            4'b1110: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        add_vec(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        add_vec(4'b0000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005);
        add_vec(4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
        add_vec(4'b0100, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001);
        add_vec(4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b0100, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        add_vec(4'b0110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        add_vec(4'b0100, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000);
        add_vec(4'b0110, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001);
        add_vec(4'b0100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        add_vec(4'b0010, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0000_0000);
        add_vec(4'b1010, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000);
        add_vec(4'b1011, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000);
        add_vec(4'b0010, 32'h8000_0000, 32'hFFFF_FFE0, 32'h8000_0000);
        add_vec(4'b1010, 32'h8000_0000, 32'hFFFF_FFE0, 32'h8000_0000);
        add_vec(4'b1011, 32'h8000_0000, 32'hFFFF_FFE0, 32'h8000_0000);
        add_vec(4'b0010, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
        add_vec(4'b1010, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
        add_vec(4'b1011, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);
        add_vec(4'b1011, 32'h4000_0000, 32'h0000_0004, 32'h0400_0000);
        add_vec(4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        add_vec(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        add_vec(4'b1110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        add_vec(4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000);
        add_vec(4'b0011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b0101, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b0111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b1001, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b1101, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
        add_vec(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000);

        // Reset state: register cleared while combinational path is live.
        rst_n  = 1'b0;
        alu_op = 4'b0000;
        in0    = 32'h0000_0010;
        in1    = 32'h0000_0020;
        #1;
        chk("reset_out_q", out_q, 32'h0);
        chk("reset_out_tracks", out, 32'h0000_0030);
        @(posedge clk);
        #1;
        chk("reset_out_q_held", out_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: combinational result/zero, then registered copy.
        foreach (vecs[i]) begin
            @(negedge clk);
            alu_op = vecs[i].op;
            in0    = vecs[i].a;
            in1    = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_out", i), out, vecs[i].exp);
            chk($sformatf("vec%0d_zero", i), 32'(zero), (vecs[i].exp == 32'h0) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_q", i), out_q, vecs[i].exp);
        end

        // Randomized: inputs change at arbitrary times, compared 0.1 later.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] e;
            #($urandom_range(1, 13));
            alu_op = 4'($urandom_range(0, 15));
            in0    = $urandom;
            in1    = (k % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if (k % 7 == 0) in0[31] = 1'b1;
            #0.1;
            e = ref_alu(alu_op, in0, in1);
            chk($sformatf("rand%0d_op%0h_out", k, alu_op), out, e);
            chk($sformatf("rand%0d_zero", k), 32'(zero), (e == 32'h0) ? 32'd1 : 32'd0);
        end

        // Mid-cycle asynchronous reset with the combinational path still live.
        @(negedge clk);
        alu_op = 4'b0000;
        in0    = 32'h0000_1000;
        in1    = 32'h0000_0234;
        @(posedge clk);
        #1;
        chk("pre_reset_out_q", out_q, 32'h0000_1234);
        #2;
        rst_n = 1'b0;
        #0.1;
        chk("async_reset_out_q", out_q, 32'h0);
        chk("async_reset_out", out, 32'h0000_1234);
        alu_op = 4'b1100;
        in0    = 32'h0F00_0000;
        in1    = 32'h0000_00F0;
        #0.1;
        chk("reset_out_or", out, 32'h0F00_00F0);
        @(posedge clk);
        #1;
        chk("reset_hold_out_q", out_q, 32'h0);

        // Release mid-cycle: register updates only at the next rising edge.
        #2;
        rst_n  = 1'b1;
        alu_op = 4'b0000;
        in0    = 32'h0000_0002;
        in1    = 32'h0000_0003;
        #0.1;
        chk("release_out", out, 32'h0000_0005);
        chk("release_out_q_pre", out_q, 32'h0);
        @(posedge clk);
        #1;
        chk("release_out_q_post", out_q, 32'h0000_0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
